// File: rtl/controle_fases_pkg.sv
// ----------------------------------------------------------------------------
// controle_fases_pkg : shared state encoding and default game sizes
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package controle_fases_pkg;

  typedef enum logic [1:0] {
    DESLIGADO      = 2'd0,
    POSICIONAMENTO = 2'd1,
    ATAQUE         = 2'd2,
    FIM            = 2'd3
  } estado_t;

  localparam int NUM_NAVIOS_PADRAO = 3;
  localparam int NUM_TIROS_PADRAO  = 8;

endpackage

`default_nettype wire

// File: rtl/controle_fases_sincroniza_botao.sv
// ----------------------------------------------------------------------------
// sincroniza_botao : two-flop synchronizer plus rising-edge detector
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sincroniza_botao (
  input  logic clk,
  input  logic rst_n,
  input  logic botao,
  output logic pulso
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= botao;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // one pulse per press, however long the button is held
  assign pulso = r_sync2 & ~r_sync3;

endmodule

`default_nettype wire

// File: rtl/controle_fases.sv
// ----------------------------------------------------------------------------
// controle_fases : game-phase FSM with ship, shot and hit counters
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module controle_fases
  import controle_fases_pkg::*;
#(
  parameter int NUM_NAVIOS = NUM_NAVIOS_PADRAO,
  parameter int NUM_TIROS  = NUM_TIROS_PADRAO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       liga,
  input  logic       btn_confirma,
  input  logic       pos_livre,
  input  logic       acerto,
  output logic       ligado,
  output logic       ataque,
  output logic       fim,
  output logic       vitoria,
  output logic       erro,
  output logic       grava_navio,
  output logic [3:0] navios,
  output logic [3:0] tiros_rest,
  output logic [3:0] acertos
);

  localparam logic [3:0] C_NAVIOS = 4'(NUM_NAVIOS);
  localparam logic [3:0] C_TIROS  = 4'(NUM_TIROS);

  logic       w_conf_p;
  estado_t    r_estado,  w_estado;
  logic [3:0] r_navios,  w_navios;
  logic [3:0] r_tiros,   w_tiros;
  logic [3:0] r_acertos, w_acertos;
  logic       r_vitoria, w_vitoria;
  logic       r_erro,    w_erro;
  logic       r_grava,   w_grava;

  sincroniza_botao u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .botao (btn_confirma),
    .pulso (w_conf_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= DESLIGADO;
      r_navios  <= 4'd0;
      r_tiros   <= 4'd0;
      r_acertos <= 4'd0;
      r_vitoria <= 1'b0;
      r_erro    <= 1'b0;
      r_grava   <= 1'b0;
    end else begin
      r_estado  <= w_estado;
      r_navios  <= w_navios;
      r_tiros   <= w_tiros;
      r_acertos <= w_acertos;
      r_vitoria <= w_vitoria;
      r_erro    <= w_erro;
      r_grava   <= w_grava;
    end
  end

  always_comb begin
    w_estado  = r_estado;
    w_navios  = r_navios;
    w_tiros   = r_tiros;
    w_acertos = r_acertos;
    w_vitoria = r_vitoria;
    w_erro    = 1'b0;
    w_grava   = 1'b0;

    // switching off overrides any confirm arriving in the same cycle
    if (!liga) begin
      w_estado  = DESLIGADO;
      w_navios  = 4'd0;
      w_tiros   = 4'd0;
      w_acertos = 4'd0;
      w_vitoria = 1'b0;
    end else begin
      case (r_estado)
        DESLIGADO: w_estado = POSICIONAMENTO;

        POSICIONAMENTO: begin
          if (w_conf_p) begin
            if (pos_livre && (r_navios < C_NAVIOS)) begin
              w_grava  = 1'b1;
              w_navios = r_navios + 4'd1;
              if (w_navios == C_NAVIOS) begin
                w_estado = ATAQUE;
                w_tiros  = C_TIROS;
              end
            end else if (!pos_livre) begin
              w_erro = 1'b1;
            end
          end
        end

        ATAQUE: begin
          if (w_conf_p && (r_tiros != 4'd0)) begin
            w_tiros = r_tiros - 4'd1;
            if (acerto) w_acertos = r_acertos + 4'd1;
            // a winning hit on the last shot counts as victory
            if (w_acertos == C_NAVIOS) begin
              w_estado  = FIM;
              w_vitoria = 1'b1;
            end else if (w_tiros == 4'd0) begin
              w_estado  = FIM;
              w_vitoria = 1'b0;
            end
          end
        end

        FIM: w_estado = FIM;

        default: w_estado = DESLIGADO;
      endcase
    end
  end

  assign ligado      = (r_estado != DESLIGADO);
  assign ataque      = (r_estado == ATAQUE) || (r_estado == FIM);
  assign fim         = (r_estado == FIM);
  assign vitoria     = r_vitoria;
  assign erro        = r_erro;
  assign grava_navio = r_grava;
  assign navios      = r_navios;
  assign tiros_rest  = r_tiros;
  assign acertos     = r_acertos;

endmodule

`default_nettype wire
